mode_header_rx: RTL

// Rx-side mode header decoder: hunts a sync word in the demodulated hard-bit stream,

---
 rtl/mode_header_rx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mode_header_rx.sv
// Hunts the sync word, decodes and CRC-checks the M/SS/BW mode header, then gates payload bits.
// Latency: sof_rx/hdr_err two edges after the last header bit; pld_bit one edge after each payload din.
// Backpressure: none; din_valid paces every counter, long din_valid gaps in a frame abort to HUNT.
module mode_header_rx #(
    parameter int                  SYNC_LEN     = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 16'hA5C3,
    parameter int                  PAYLOAD_BITS = 1024,
    parameter int                  TIMEOUT      = 4095,
    parameter int                  M_MAX        = 5,
    parameter int                  BW_MAX       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    output logic [2:0] index_M,
    output logic [3:0] index_SS,
    output logic [2:0] index_BW,
    output logic       sof_rx,
    output logic       pld_bit,
    output logic       pld_valid,
    output logic       locked,
    output logic       hdr_err,
    output logic [7:0] err_cnt
);
    localparam int PCW = $clog2(PAYLOAD_BITS + 1);
    localparam int ICW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] M_MAX3  = 3'(M_MAX);
    localparam logic [2:0] BW_MAX3 = 3'(BW_MAX);

    typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD} state_t;
    state_t state, state_nxt;

    logic [SYNC_LEN-1:0] sync_sr, sync_shift;
    logic [12:0]         hdr_sr;
    logic [13:0]         hdr_full;
    logic [3:0]          hdr_cnt, crc, crc_upd;
    logic [PCW-1:0]      pld_cnt;
    logic [ICW-1:0]      idle_cnt;
    logic [9:0]          fld_q;
    logic                pend_good, pend_bad;
    logic                hdr_last, hdr_good, timeout, pld_last;

    always_comb begin
        sync_shift = {sync_sr[SYNC_LEN-2:0], din};
        hdr_full   = {hdr_sr, din};
        crc_upd    = {crc[2:0], 1'b0} ^ ((crc[3] ^ din) ? 4'b0011 : 4'b0000);
        hdr_last   = (state == HEADER) && din_valid && (hdr_cnt == 4'd13);
        // crc already covers all 10 field bits by the time the 14th bit arrives
        hdr_good   = (crc == hdr_full[3:0]) &&
                     (hdr_full[13:11] >= 3'd1) && (hdr_full[13:11] <= M_MAX3) &&
                     (hdr_full[10:7] != 4'd0) && (hdr_full[6:4] <= BW_MAX3);
        timeout    = (state != HUNT) && !din_valid && (idle_cnt == ICW'(TIMEOUT - 1));
        pld_last   = (pld_cnt == PCW'(PAYLOAD_BITS - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (din_valid && (sync_shift == SYNC_WORD)) state_nxt = HEADER;
            HEADER:  if (timeout) state_nxt = HUNT;
                     else if (hdr_last) state_nxt = hdr_good ? PAYLOAD : HUNT;
            PAYLOAD: if (timeout || (din_valid && pld_last)) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr   <= '0;
            hdr_sr    <= '0;
            hdr_cnt   <= '0;
            crc       <= '0;
            pld_cnt   <= '0;
            idle_cnt  <= '0;
            fld_q     <= '0;
            pend_good <= 1'b0;
            pend_bad  <= 1'b0;
            index_M   <= 3'd1;
            index_SS  <= 4'd1;
            index_BW  <= 3'd0;
            sof_rx    <= 1'b0;
            hdr_err   <= 1'b0;
            err_cnt   <= 8'd0;
            pld_bit   <= 1'b0;
            pld_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            // holding zero outside HUNT means every re-entry hunts on fresh bits only
            if (state != HUNT)  sync_sr <= '0;
            else if (din_valid) sync_sr <= sync_shift;

            if (state == HUNT) begin
                hdr_cnt <= '0;
                crc     <= '0;
            end else if ((state == HEADER) && din_valid) begin
                hdr_sr  <= hdr_full[12:0];
                hdr_cnt <= hdr_cnt + 4'd1;
                if (hdr_cnt < 4'd10) crc <= crc_upd;
            end

            pend_good <= hdr_last && hdr_good;
            pend_bad  <= hdr_last && !hdr_good;
            if (hdr_last) fld_q <= hdr_full[13:4];

            sof_rx  <= pend_good;
            hdr_err <= pend_bad;
            if (pend_good) begin
                index_M  <= fld_q[9:7];
                index_SS <= fld_q[6:3];
                index_BW <= fld_q[2:0];
            end
            if ((pend_bad || timeout) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

            if (din_valid)                    idle_cnt <= '0;
            else if (idle_cnt != ICW'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;

            pld_valid <= (state == PAYLOAD) && din_valid;
            if ((state == PAYLOAD) && din_valid) pld_bit <= din;
            if (state != PAYLOAD) pld_cnt <= '0;
            else if (din_valid)   pld_cnt <= pld_cnt + 1'b1;

            locked <= (state == PAYLOAD);
        end
    end
endmodule
